aes_key_sched: RTL and testbench

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_key_sched_if.sv | 26 ++
 rtl/aes_key_sched.sv | 178 +++++++++++++++++
 tb/tb_aes_key_sched.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_if.sv
// aes_key_sched_if -- request/round-key bus for the AES-128 key scheduler.
//   start/dir/key_in : expansion request (key in state-matrix form, key_in[r][c] = byte 4c+r)
//   busy/done        : run status, done is a one-cycle pulse after the last key transfer
//   rk_valid/rk_ready: valid/ready handshake carrying rk_out (matrix form) and rk_round
// master = key consumer / requester, slave = aes_key_sched.
interface aes_key_sched_if;
  logic                   start;
  logic                   dir;
  logic [0:3][0:3][7:0]   key_in;
  logic                   busy;
  logic                   rk_valid;
  logic                   rk_ready;
  logic [0:3][0:3][7:0]   rk_out;
  logic [3:0]             rk_round;
  logic                   done;

  modport master (
    output start, dir, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_round, done
  );

  modport slave (
    input  start, dir, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_round, done
  );
endinterface

// File: rtl/aes_key_sched.sv
// aes_key_sched -- AES-128 key expansion with ordered round-key emission.
// A start in IDLE latches key_in (round 0) and dir, then one round key per
// cycle is expanded into an 11-entry store. The keys are then offered on a
// valid/ready handshake in order 0..10 (dir=0) or 10..0 (dir=1).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, priority over start
//   bus : aes_key_sched_if.slave (start, dir, key_in, busy, rk_valid,
//         rk_ready, rk_out, rk_round, done)
module aes_key_sched (
  input  logic           clk,
  input  logic           rst,
  aes_key_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Internally a round key is 128 bits {w0,w1,w2,w3}, w0 in the MSBs,
  // word wc = {M[0][c],M[1][c],M[2][c],M[3][c]}; i.e. byte 4c+r at the top.
  function automatic logic [127:0] mat2flat(input logic [0:3][0:3][7:0] m);
    logic [127:0] f;
    f = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        f[127 - 8*(4*c + r) -: 8] = m[r][c];
    return f;
  endfunction

  function automatic logic [0:3][0:3][7:0] flat2mat(input logic [127:0] f);
    logic [0:3][0:3][7:0] m;
    m = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        m[r][c] = f[127 - 8*(4*c + r) -: 8];
    return m;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_t       state_q;
  logic         busy_q;
  logic         rk_valid_q;
  logic         done_q;
  logic         dir_q;
  logic [3:0]   cnt_q;       // round being expanded in EXPAND, keys transferred in EMIT
  logic [7:0]   rcon_q;
  logic [127:0] last_q;      // most recently expanded round key
  logic [127:0] rk_out_q;
  logic [3:0]   rk_round_q;
  logic [127:0] store_q [11];

  logic [127:0] key_flat;
  logic [127:0] next_rk;
  logic [31:0]  rot_w, t_w, nw0, nw1, nw2, nw3;
  logic [3:0]   cur_idx, nxt_idx;

  assign key_flat = mat2flat(bus.key_in);

  always_comb begin
    rot_w   = {last_q[23:0], last_q[31:24]};
    t_w     = sub_word(rot_w) ^ {rcon_q, 24'h000000};
    nw0     = last_q[127:96] ^ t_w;
    nw1     = last_q[95:64]  ^ nw0;
    nw2     = last_q[63:32]  ^ nw1;
    nw3     = last_q[31:0]   ^ nw2;
    next_rk = {nw0, nw1, nw2, nw3};
  end

  // Emission index derived from the transfer count so both orders share one counter.
  always_comb begin
    cur_idx = dir_q ? (4'd10 - cnt_q) : cnt_q;
    nxt_idx = dir_q ? (4'd9 - cnt_q) : (cnt_q + 4'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == IDLE && bus.start)
        store_q[0] <= key_flat;
      else if (state_q == EXPAND)
        store_q[cnt_q] <= next_rk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      rcon_q     <= '0;
      last_q     <= '0;
      rk_out_q   <= '0;
      rk_round_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            last_q  <= key_flat;
            dir_q   <= bus.dir;
            cnt_q   <= 4'd1;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b1;
            state_q <= EXPAND;
          end
        end
        EXPAND: begin
          last_q <= next_rk;
          rcon_q <= xtime(rcon_q);
          if (cnt_q == 4'd10) begin
            cnt_q   <= '0;
            state_q <= EMIT;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        EMIT: begin
          // First EMIT cycle only loads the output register, so the first
          // key is offered one cycle after round 10 is stored.
          if (!rk_valid_q) begin
            rk_valid_q <= 1'b1;
            rk_out_q   <= store_q[cur_idx];
            rk_round_q <= cur_idx;
          end else if (bus.rk_ready) begin
            if (cnt_q == 4'd10) begin
              rk_valid_q <= 1'b0;
              rk_out_q   <= '0;
              rk_round_q <= '0;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              cnt_q      <= '0;
              state_q    <= IDLE;
            end else begin
              cnt_q      <= cnt_q + 4'd1;
              rk_out_q   <= store_q[nxt_idx];
              rk_round_q <= nxt_idx;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.done     = done_q;
  assign bus.rk_round = rk_round_q;
  assign bus.rk_out   = flat2mat(rk_out_q);

endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched -- self-checking bench for aes_key_sched.
// A table of runs (key, order, backpressure mode, corner-case flags) is
// applied in a loop; expected round keys come from an arithmetic AES key
// expansion model (GF(2^8) inverse + affine S-box) and are queued per run,
// then popped and compared as keys transfer. FIPS-197 constants are checked
// directly on top of the model.
module tb_aes_key_sched;

  typedef logic [0:3][0:3][7:0] mat_t;
  typedef logic [127:0] ks_t [11];

  typedef struct {
    logic [127:0] key;
    bit           dir;
    bit           has_exp;
    logic [127:0] r1;
    logic [127:0] r10;
    int unsigned  mode;       // 0: always ready, 1: random ready with stall
    int unsigned  stall;      // round index stalled for 20 cycles in mode 1
    bit           inject;     // pulse start with another key during EXPAND
    bit           chain;      // start next run in this run's done cycle
    bit           abort_before;
  } vec_t;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  logic clk;
  logic rst;
  aes_key_sched_if bus ();

  aes_key_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_tests;
  int   n_fail;
  exp_t exp_q [$];
  vec_t vecs [7];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic mat_t to_mat(input logic [127:0] f);
    mat_t m;
    m = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = f[127 - 8*(4*c + r) -: 8];
    return m;
  endfunction

  function automatic logic [127:0] from_mat(input mat_t m);
    logic [127:0] f;
    f = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        f[127 - 8*(4*c + r) -: 8] = m[r][c];
    return f;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic expand_model(input logic [127:0] key, output ks_t ks);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic drive_start(input vec_t v);
    bus.start  = 1'b1;
    bus.key_in = to_mat(v.key);
    bus.dir    = v.dir;
  endtask

  // Called #1 after a posedge with start already driven; the next edge accepts.
  task automatic run_body(input int vi);
    vec_t         v;
    ks_t          ks;
    exp_t         e;
    int unsigned  cyc, xfers, stall_cnt, first_valid;
    bit           prev_hold, rdy, finished;
    logic [127:0] prev_out, cur_out;
    logic [3:0]   prev_round;
    v = vecs[vi];
    expand_model(v.key, ks);
    exp_q.delete();
    for (int k = 0; k < 11; k++) begin
      e.idx = v.dir ? 4'(10 - k) : 4'(k);
      e.key = ks[e.idx];
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.key_in = to_mat({$urandom, $urandom, $urandom, $urandom});
    bus.dir    = ~v.dir;
    chk("busy_after_accept", bus.busy, 1'b1);
    cyc = 0; xfers = 0; stall_cnt = 0; first_valid = 0;
    prev_hold = 0; finished = 0; prev_out = '0; prev_round = '0;
    while (!finished && cyc < 300) begin
      @(posedge clk); cyc++; #1;
      bus.start = 1'b0;
      cur_out = from_mat(bus.rk_out);
      if (xfers == 11) begin
        chk("done_pulse", bus.done, 1'b1);
        chk("busy_low_at_done", bus.busy, 1'b0);
        chk("valid_low_at_done", bus.rk_valid, 1'b0);
        if (v.chain) drive_start(vecs[vi+1]);
        else begin
          @(posedge clk); #1;
          chk("done_one_cycle", bus.done, 1'b0);
        end
        finished = 1;
      end else if (bus.rk_valid) begin
        if (first_valid == 0) begin
          first_valid = cyc;
          chk("first_valid_latency", 128'(cyc), 128'd11);
        end
        if (prev_hold) begin
          chk("stall_rk_out_stable", cur_out, prev_out);
          chk("stall_rk_round_stable", bus.rk_round, prev_round);
        end
        if (v.mode == 0) rdy = 1'b1;
        else if (bus.rk_round == v.stall[3:0] && stall_cnt < 20) begin
          rdy = 1'b0;
          stall_cnt++;
        end else rdy = 1'($urandom_range(0, 1));
        bus.rk_ready = rdy;
        if (rdy) begin
          if (exp_q.size() == 0) chk("extra_key", 128'd1, 128'd0);
          else begin
            e = exp_q.pop_front();
            chk("rk_round_order", bus.rk_round, e.idx);
            chk("rk_out_model", cur_out, e.key);
            if (v.has_exp && e.idx == 4'd1)  chk("rk_out_round1_const", cur_out, v.r1);
            if (v.has_exp && e.idx == 4'd10) chk("rk_out_round10_const", cur_out, v.r10);
          end
          xfers++;
          prev_hold = 0;
        end else begin
          prev_hold  = 1;
          prev_out   = cur_out;
          prev_round = bus.rk_round;
        end
      end else begin
        chk("zero_when_invalid", cur_out | {124'b0, bus.rk_round}, '0);
        if (prev_hold || (first_valid != 0 && v.mode == 0))
          chk("valid_dropped", bus.rk_valid, 1'b1);
        if (first_valid == 0) chk("busy_during_expand", bus.busy, 1'b1);
        bus.rk_ready = (v.mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (v.inject && cyc == 3) begin
        bus.start  = 1'b1;
        bus.key_in = to_mat(~v.key);
        bus.dir    = ~v.dir;
      end
    end
    if (!finished) chk("run_timeout", 128'(xfers), 128'd11);
  endtask

  task automatic do_abort();
    int unsigned viol;
    vec_t a;
    a = vecs[0];
    drive_start(a);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_valid", bus.rk_valid, 1'b0);
    viol = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.rk_valid !== 1'b0 || bus.done !== 1'b0) viol++;
    end
    chk("abort_quiet", 128'(viol), 128'd0);
  endtask

  initial begin
    bit prestarted;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.start    = 1'b1;
    bus.dir      = 1'b0;
    bus.key_in   = to_mat(FIPS_KEY);
    bus.rk_ready = 1'b0;

    vecs[0] = '{key: FIPS_KEY, dir: 0, has_exp: 1, r1: FIPS_R1, r10: FIPS_R10, mode: 0, stall: 0, inject: 0, chain: 0, abort_before: 0};
    vecs[1] = '{key: FIPS_KEY, dir: 1, has_exp: 1, r1: FIPS_R1, r10: FIPS_R10, mode: 0, stall: 0, inject: 0, chain: 1, abort_before: 0};
    vecs[2] = '{key: FIPS_KEY, dir: 0, has_exp: 1, r1: FIPS_R1, r10: FIPS_R10, mode: 1, stall: 5, inject: 0, chain: 0, abort_before: 0};
    vecs[3] = '{key: FIPS_KEY, dir: 0, has_exp: 1, r1: FIPS_R1, r10: FIPS_R10, mode: 0, stall: 0, inject: 1, chain: 0, abort_before: 0};
    vecs[4] = '{key: {$urandom, $urandom, $urandom, $urandom}, dir: 1, has_exp: 0, r1: '0, r10: '0, mode: 1, stall: 0, inject: 0, chain: 1, abort_before: 0};
    vecs[5] = '{key: {$urandom, $urandom, $urandom, $urandom}, dir: 0, has_exp: 0, r1: '0, r10: '0, mode: 0, stall: 0, inject: 0, chain: 0, abort_before: 0};
    vecs[6] = '{key: '0, dir: 0, has_exp: 1, r1: ZERO_R1, r10: ZERO_R10, mode: 0, stall: 0, inject: 0, chain: 0, abort_before: 1};

    // Reset held with start high: reset must win.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_valid", bus.rk_valid, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_rk_out", from_mat(bus.rk_out), '0);
    chk("reset_rk_round", bus.rk_round, 4'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", bus.busy, 1'b0);

    prestarted = 0;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].abort_before) do_abort();
      if (!prestarted) drive_start(vecs[i]);
      run_body(i);
      prestarted = vecs[i].chain;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
